// File: rtl/tawas_sched_pkg.sv
// Shared definitions for the Tawas hardware-thread scheduler.
//   - thread_state_e : 2-bit per-thread state encoding
//   - DEF_NTHREADS / DEF_TW : default thread count and thread-id width
package tawas_sched_pkg;

   localparam int unsigned DEF_NTHREADS = 16;
   localparam int unsigned DEF_TW       = 4;

   typedef enum logic [1:0] {
      TS_HALTED = 2'd0,
      TS_READY  = 2'd1,
      TS_BUSY   = 2'd2
   } thread_state_e;

endpackage : tawas_sched_pkg

// File: rtl/tawas_rr_pick.sv
// Combinational round-robin picker: returns the first set request at or
// after ptr, wrapping modulo N.
//   req     in  N  request vector
//   ptr     in  W  search start position
//   valid_c out 1  at least one request is set
//   idx_c   out W  index of the winning request (0 when none)
// N must equal 2**W so that index arithmetic wraps naturally.
module tawas_rr_pick
   import tawas_sched_pkg::*;
#(
   parameter int unsigned N = DEF_NTHREADS,
   parameter int unsigned W = DEF_TW
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic         valid_c,
   output logic [W-1:0] idx_c
);

   logic [N-1:0] rot_c;
   logic [W-1:0] enc_c;

   // Rotate so ptr lands on bit 0, priority-encode lowest, rotate back.
   always_comb begin
      rot_c = N'({req, req} >> ptr);
      enc_c = '0;
      for (int i = int'(N) - 1; i >= 0; i--) begin
         if (rot_c[i]) enc_c = W'(i);
      end
      valid_c = |req;
      idx_c   = enc_c + ptr;
   end

endmodule : tawas_rr_pick

// File: rtl/tawas_thread_sched.sv
// Round-robin hardware-thread scheduler for the Tawas core.
// Tracks HALTED/READY/BUSY per thread, issues at most one READY and
// unmasked thread per cycle while fewer than MAX_INFLIGHT are BUSY, and
// moves threads back on retire (READY or HALTED) and on wake (HALTED->READY).
//   clk, rst             clock, asynchronous active-high reset
//   thread_mask          per-thread issue enable
//   wake_en/wake_thread  wake request
//   retire_en/retire_thread/retire_halt  retire from backend
//   issue_en/issue_thread                registered issue
//   thread_busy/thread_halted            registered state vectors
//   inflight                             registered BUSY count
// Optional: define TAWAS_SCHED_STATS_EN to add stat_issue_cnt and
// stat_stall_cnt (32-bit wrapping counters).
module tawas_thread_sched
   import tawas_sched_pkg::*;
#(
   parameter int unsigned NTHREADS     = DEF_NTHREADS,
   parameter int unsigned TW           = DEF_TW,
   parameter int unsigned MAX_INFLIGHT = 4,
   parameter logic [15:0] RST_READY    = 16'h0001
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NTHREADS-1:0] thread_mask,
   input  logic                wake_en,
   input  logic [TW-1:0]       wake_thread,
   input  logic                retire_en,
   input  logic [TW-1:0]       retire_thread,
   input  logic                retire_halt,
   output logic                issue_en,
   output logic [TW-1:0]       issue_thread,
   output logic [NTHREADS-1:0] thread_busy,
   output logic [NTHREADS-1:0] thread_halted,
   output logic [TW:0]         inflight
`ifdef TAWAS_SCHED_STATS_EN
   ,
   output logic [31:0]         stat_issue_cnt,
   output logic [31:0]         stat_stall_cnt
`endif
);

   localparam logic [NTHREADS-1:0] RST_VEC = RST_READY[NTHREADS-1:0];
   localparam logic [TW:0]         MAX_CNT = (TW+1)'(MAX_INFLIGHT);

   thread_state_e       state_q [NTHREADS];
   thread_state_e       state_d [NTHREADS];
   logic [TW-1:0]       rr_ptr_q;
   logic [NTHREADS-1:0] eligible_c;
   logic                any_elig_c;
   logic [TW-1:0]       pick_idx_c;
   logic                pick_ok_c;
   logic                retire_ok_c;
   logic [TW:0]         inflight_d;
   logic [NTHREADS-1:0] busy_d;
   logic [NTHREADS-1:0] halted_d;

   // Eligible threads: READY and not masked.
   always_comb begin
      eligible_c = '0;
      for (int i = 0; i < int'(NTHREADS); i++) begin
         eligible_c[i] = (state_q[i] == TS_READY) && thread_mask[i];
      end
   end

   tawas_rr_pick #(
      .N (NTHREADS),
      .W (TW)
   ) u_pick (
      .req     (eligible_c),
      .ptr     (rr_ptr_q),
      .valid_c (any_elig_c),
      .idx_c   (pick_idx_c)
   );

   assign pick_ok_c   = any_elig_c && (inflight < MAX_CNT);
   assign retire_ok_c = retire_en && (state_q[retire_thread] == TS_BUSY);

   // Next state: issue, then retire, then wake. Wake sees the post-retire
   // state so a retire-with-halt plus wake of the same thread ends READY,
   // while a wake of a thread still BUSY is dropped.
   always_comb begin
      state_d    = state_q;
      inflight_d = inflight;
      busy_d     = '0;
      halted_d   = '0;

      if (pick_ok_c) state_d[pick_idx_c] = TS_BUSY;
      if (retire_ok_c) state_d[retire_thread] = retire_halt ? TS_HALTED : TS_READY;
      if (wake_en && (state_d[wake_thread] == TS_HALTED)) state_d[wake_thread] = TS_READY;

      case ({pick_ok_c, retire_ok_c})
         2'b10:   inflight_d = inflight + (TW+1)'(1);
         2'b01:   inflight_d = inflight - (TW+1)'(1);
         default: inflight_d = inflight;
      endcase

      for (int i = 0; i < int'(NTHREADS); i++) begin
         busy_d[i]   = (state_d[i] == TS_BUSY);
         halted_d[i] = (state_d[i] == TS_HALTED);
      end
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(NTHREADS); i++) begin
            state_q[i] <= RST_VEC[i] ? TS_READY : TS_HALTED;
         end
         rr_ptr_q      <= '0;
         issue_en      <= 1'b0;
         issue_thread  <= '0;
         inflight      <= '0;
         thread_busy   <= '0;
         thread_halted <= ~RST_VEC;
      end else begin
         for (int i = 0; i < int'(NTHREADS); i++) begin
            state_q[i] <= state_d[i];
         end
         issue_en      <= pick_ok_c;
         if (pick_ok_c) begin
            issue_thread <= pick_idx_c;
            rr_ptr_q     <= pick_idx_c + TW'(1);
         end
         inflight      <= inflight_d;
         thread_busy   <= busy_d;
         thread_halted <= halted_d;
      end
   end

`ifdef TAWAS_SCHED_STATS_EN
   // Issue count and stalls caused by the in-flight limit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_issue_cnt <= '0;
         stat_stall_cnt <= '0;
      end else begin
         if (pick_ok_c) stat_issue_cnt <= stat_issue_cnt + 32'd1;
         if (any_elig_c && (inflight == MAX_CNT)) stat_stall_cnt <= stat_stall_cnt + 32'd1;
      end
   end
`endif

endmodule : tawas_thread_sched

// File: tb/tb_tawas_thread_sched.sv
// Directed testbench for tawas_thread_sched (default parameters).
module tb_tawas_thread_sched;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] thread_mask;
   logic        wake_en;
   logic [3:0]  wake_thread;
   logic        retire_en;
   logic [3:0]  retire_thread;
   logic        retire_halt;
   logic        issue_en;
   logic [3:0]  issue_thread;
   logic [15:0] thread_busy;
   logic [15:0] thread_halted;
   logic [4:0]  inflight;
`ifdef TAWAS_SCHED_STATS_EN
   logic [31:0] stat_issue_cnt;
   logic [31:0] stat_stall_cnt;
`endif

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   tawas_thread_sched u_dut (
      .clk           (clk),
      .rst           (rst),
      .thread_mask   (thread_mask),
      .wake_en       (wake_en),
      .wake_thread   (wake_thread),
      .retire_en     (retire_en),
      .retire_thread (retire_thread),
      .retire_halt   (retire_halt),
      .issue_en      (issue_en),
      .issue_thread  (issue_thread),
      .thread_busy   (thread_busy),
      .thread_halted (thread_halted),
      .inflight      (inflight)
`ifdef TAWAS_SCHED_STATS_EN
      ,
      .stat_issue_cnt (stat_issue_cnt),
      .stat_stall_cnt (stat_stall_cnt)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_state(input string tag, input logic en, input logic [3:0] thr,
                            input logic [4:0] inf, input logic [15:0] busy,
                            input logic [15:0] halt);
      check({tag, ".issue_en"},      32'(issue_en),      32'(en));
      check({tag, ".issue_thread"},  32'(issue_thread),  32'(thr));
      check({tag, ".inflight"},      32'(inflight),      32'(inf));
      check({tag, ".thread_busy"},   32'(thread_busy),   32'(busy));
      check({tag, ".thread_halted"}, 32'(thread_halted), 32'(halt));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; thread_mask = 16'hFFFF;
      wake_en = 1'b0; wake_thread = 4'd0;
      retire_en = 1'b0; retire_thread = 4'd0; retire_halt = 1'b0;
      tick(); tick();
      chk_state("reset", 1'b0, 4'd0, 5'd0, 16'h0000, 16'hFFFE);
      rst = 1'b0;

      // Thread 0 issues at the first edge, then waits for its retire.
      tick(); chk_state("first_issue", 1'b1, 4'd0, 5'd1, 16'h0001, 16'hFFFE);
      tick(); chk_state("no_reissue",  1'b0, 4'd0, 5'd1, 16'h0001, 16'hFFFE);
      retire_en = 1'b1; retire_thread = 4'd0;
      tick(); retire_en = 1'b0;
      chk_state("retire0",  1'b0, 4'd0, 5'd0, 16'h0000, 16'hFFFE);
      tick(); chk_state("reissue0", 1'b1, 4'd0, 5'd1, 16'h0001, 16'hFFFE);

      // Halt thread 0, then wake 1,2,3,5,7 one per cycle.
      retire_en = 1'b1; retire_thread = 4'd0; retire_halt = 1'b1;
      tick(); retire_en = 1'b0; retire_halt = 1'b0;
      chk_state("halt0", 1'b0, 4'd0, 5'd0, 16'h0000, 16'hFFFF);
      wake_en = 1'b1; wake_thread = 4'd1;
      tick(); chk_state("wake1", 1'b0, 4'd0, 5'd0, 16'h0000, 16'hFFFD);
      wake_thread = 4'd2;
      tick(); chk_state("iss1", 1'b1, 4'd1, 5'd1, 16'h0002, 16'hFFF9);
      wake_thread = 4'd3;
      tick(); chk_state("iss2", 1'b1, 4'd2, 5'd2, 16'h0006, 16'hFFF1);
      wake_thread = 4'd5;
      tick(); chk_state("iss3", 1'b1, 4'd3, 5'd3, 16'h000E, 16'hFFD1);
      wake_thread = 4'd7;
      tick(); chk_state("iss5", 1'b1, 4'd5, 5'd4, 16'h002E, 16'hFF51);
      wake_en = 1'b0;
      tick(); chk_state("full", 1'b0, 4'd5, 5'd4, 16'h002E, 16'hFF51);
`ifdef TAWAS_SCHED_STATS_EN
      check("stat_issue_a", stat_issue_cnt, 32'd6);
      check("stat_stall_a", stat_stall_cnt, 32'd1);
`endif

      // Wake of BUSY thread 1 dropped; retire of READY thread 7 ignored.
      wake_en = 1'b1; wake_thread = 4'd1; retire_en = 1'b1; retire_thread = 4'd7;
      tick(); chk_state("drop", 1'b0, 4'd5, 5'd4, 16'h002E, 16'hFF51);

      // Retire-with-halt and wake of thread 1 together: ends READY.
      retire_thread = 4'd1; retire_halt = 1'b1;
      tick(); wake_en = 1'b0; retire_en = 1'b0; retire_halt = 1'b0;
      chk_state("ret_wake1", 1'b0, 4'd5, 5'd3, 16'h002C, 16'hFF51);
      tick(); chk_state("iss7", 1'b1, 4'd7, 5'd4, 16'h00AC, 16'hFF51);

      // Halt thread 2; only thread 1 is issued afterwards.
      retire_en = 1'b1; retire_thread = 4'd2; retire_halt = 1'b1;
      tick(); retire_en = 1'b0; retire_halt = 1'b0;
      chk_state("halt2", 1'b0, 4'd7, 5'd3, 16'h00A8, 16'hFF55);
      tick(); chk_state("iss1b", 1'b1, 4'd1, 5'd4, 16'h00AA, 16'hFF55);

      // Mask thread 1 and retire it: READY but never issued while masked.
      thread_mask = 16'hFFFD; retire_en = 1'b1; retire_thread = 4'd1;
      tick(); retire_en = 1'b0;
      chk_state("ret1", 1'b0, 4'd1, 5'd3, 16'h00A8, 16'hFF55);
      tick(); tick(); tick();
      chk_state("masked", 1'b0, 4'd1, 5'd3, 16'h00A8, 16'hFF55);

      // Unmask and wake thread 2: 1 issues now, 2 once a slot frees.
      thread_mask = 16'hFFFF; wake_en = 1'b1; wake_thread = 4'd2;
      tick(); wake_en = 1'b0;
      chk_state("unmask", 1'b1, 4'd1, 5'd4, 16'h00AA, 16'hFF51);
      retire_en = 1'b1; retire_thread = 4'd3;
      tick(); retire_en = 1'b0;
      chk_state("ret3", 1'b0, 4'd1, 5'd3, 16'h00A2, 16'hFF51);
      tick(); chk_state("iss2b", 1'b1, 4'd2, 5'd4, 16'h00A6, 16'hFF51);
`ifdef TAWAS_SCHED_STATS_EN
      check("stat_issue_b", stat_issue_cnt, 32'd10);
      check("stat_stall_b", stat_stall_cnt, 32'd5);
`endif

      // Asynchronous reset mid-cycle: outputs return immediately.
      rst = 1'b1; thread_mask = 16'h0000;
      #1;
      chk_state("async_rst", 1'b0, 4'd0, 5'd0, 16'h0000, 16'hFFFE);
`ifdef TAWAS_SCHED_STATS_EN
      check("stat_issue_rst", stat_issue_cnt, 32'd0);
      check("stat_stall_rst", stat_stall_cnt, 32'd0);
`endif
      tick(); rst = 1'b0;

      // Fairness: make 0..3 READY while masked, then unmask and retire
      // each thread three edges after it issues.
      wake_en = 1'b1;
      for (int t = 1; t < 4; t++) begin
         wake_thread = 4'(t);
         tick();
      end
      wake_en = 1'b0;
      chk_state("rr_ready", 1'b0, 4'd0, 5'd0, 16'h0000, 16'hFFF0);
      thread_mask = 16'h000F;
      for (int k = 1; k <= 12; k++) begin
         retire_en     = (k >= 4);
         retire_thread = 4'((k + 4) % 4);
         tick();
         check($sformatf("rr%0d.issue_en", k), 32'(issue_en), 32'd1);
         check($sformatf("rr%0d.issue_thread", k), 32'(issue_thread), 32'((k - 1) % 4));
      end
      retire_en = 1'b0;
      check("rr_end.inflight", 32'(inflight), 32'd3);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_tawas_thread_sched

// File: doc/tawas_thread_sched.md
Name: tawas_thread_sched

Overview:
- Round-robin hardware-thread scheduler for the Tawas core.
- Tracks per-thread state (HALTED / READY / BUSY) for up to 16 threads and issues at most one thread per cycle to the fetch pipeline.
- Bounds the number of threads in flight and returns each thread to READY or HALTED when the backend retires it.
- Wake requests come from software or interrupts and restart halted threads.

Parameters:
- NTHREADS, 16, number of hardware threads (power of 2, 2..16).
- TW, 4, thread-id width, equal to log2(NTHREADS).
- MAX_INFLIGHT, 4, maximum BUSY threads at once (pipeline depth, 1..NTHREADS).
- RST_READY, 16'h0001, threads READY out of reset; all others HALTED.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- thread_mask  in  NTHREADS  per-thread enable; a masked thread is never issued but keeps its state
- wake_en  in  1  wake request strobe
- wake_thread  in  TW  thread to wake
- retire_en  in  1  thread retire strobe from the backend
- retire_thread  in  TW  retiring thread id
- retire_halt  in  1  retiring thread executed halt; it goes to HALTED
- issue_en  out  1  registered; a thread is issued this cycle
- issue_thread  out  TW  registered issued thread id
- thread_busy  out  NTHREADS  registered BUSY vector
- thread_halted  out  NTHREADS  registered HALTED vector
- inflight  out  TW+1  registered count of BUSY threads

Behaviour:
- Reset:
  - state[i] = READY if RST_READY[i], else HALTED.
  - issue_en=0, issue_thread=0, inflight=0, rr_ptr=0.
  - thread_busy=0; thread_halted=~RST_READY.
- Eligible(i) = state[i]==READY && thread_mask[i].
- Pick, evaluated combinationally from current registered state:
  - Search starts at rr_ptr and wraps modulo NTHREADS; the first eligible thread wins.
  - The pick is valid only if at least one thread is eligible and inflight < MAX_INFLIGHT.
- On posedge with a valid pick p:
  - issue_en<=1, issue_thread<=p, state[p]<=BUSY.
  - rr_ptr<=(p+1) mod NTHREADS.
- With no valid pick: issue_en<=0; issue_thread holds; rr_ptr holds.
- Retire on posedge (retire_en=1):
  - If state[retire_thread]==BUSY, it goes to HALTED when retire_halt=1, otherwise READY.
  - A retire for a non-BUSY thread is ignored; no state or count change.
- Wake on posedge (wake_en=1):
  - If state[wake_thread]==HALTED, it goes to READY.
  - Otherwise the wake is ignored (no queuing).
- Simultaneous events:
  - The pick uses pre-edge state, so a thread retired at edge N is first issuable at edge N+1.
  - Retire and wake of the same thread in one cycle: retire is applied first. If retire_halt=1 the wake then applies and the thread ends READY; if retire_halt=0 it ends READY.
  - A wake of a thread that is BUSY in the same cycle is dropped.
- inflight:
  - +1 on a valid pick, -1 on a valid retire, unchanged when both occur.
  - Never exceeds MAX_INFLIGHT and never underflows.
- Latency:
  - Retire at edge N to re-issue at earliest edge N+1, with issue_en visible after that edge.
  - Reset-ready thread 0 issues at the first edge after rst deasserts.
- thread_mask change takes effect on the next pick; a BUSY masked thread still retires normally.
- Reset mid-operation: all state is restored to reset values immediately (asynchronous). In-flight retires are lost and the backend must be reset together with this block.

Optional Feature:
- Macro: TAWAS_SCHED_STATS_EN.
- Defined: adds outputs stat_issue_cnt[31:0] and stat_stall_cnt[31:0], both reset to 0.
  - stat_issue_cnt increments on every valid pick.
  - stat_stall_cnt increments on cycles where an eligible thread exists but inflight==MAX_INFLIGHT.
  - Both wrap at 2^32.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package tawas_sched_pkg holds:
  - 2-bit thread-state encoding: HALTED=2'd0, READY=2'd1, BUSY=2'd2.
  - Default NTHREADS/TW constants.
- One sub-module: tawas_rr_pick. It is combinational: rotate-by-rr_ptr, priority-encode, rotate back, giving a valid bit and a TW-bit index. Reused by other arbiters in the core.

Test Plan:
- Reset with RST_READY=16'h0001, mask=16'hFFFF:
  - Thread 0 issues at the first edge and inflight=1.
  - No further issue until retire_en=1/retire_thread=0; thread 0 re-issues the edge after the retire.
- Wake threads 1,2,3,5 with RST_READY=0 and MAX_INFLIGHT=4, no retires:
  - Issue order is 1,2,3,5, then issue_en=0.
  - inflight=4; stat_stall_cnt increments while any thread is READY, when TAWAS_SCHED_STATS_EN is defined.
- Round-robin fairness, threads 0..3 READY, each retired 3 cycles after issue:
  - Sequence is 0,1,2,3,0,1,…; no thread is issued twice before the others.
- Halt: retire thread 2 with retire_halt=1:
  - thread_halted[2]=1 and thread 2 is never issued.
  - wake_thread=2 brings it back; issued within NTHREADS cycles.
- Same-cycle events:
  - Retire (halt=1) and wake of thread 4 together: thread 4 ends READY.
  - Wake of BUSY thread 6: dropped.
  - Retire of non-BUSY thread 7: inflight unchanged.
- Mask thread 1 while it is READY: it is skipped. Assert rst mid-run: all outputs return to reset values on the same cycle.
